mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between instruction fetch (IF, read-only) and the load/store path (LS).

---
 rtl/mem_port_arbiter_pkg.sv | 30 +++
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter_byte_lane_gen.sv | 36 +++
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/LS memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Request fields latched at grant and replayed on the memory port.
    typedef struct packed {
        owner_e          owner;
        logic            we;
        logic [BW-1:0]   bmask;
        logic [DW-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32
);
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic          o_if_gnt;
    logic          o_if_rvalid;
    logic [31:0]   o_if_rdata;
    logic          o_if_err;

    logic          i_ls_req;
    logic          i_ls_we;
    logic [AW-1:0] i_ls_addr;
    logic [31:0]   i_ls_wdata;
    logic [1:0]    i_ls_size;
    logic          o_ls_gnt;
    logic          o_ls_rvalid;
    logic [31:0]   o_ls_rdata;
    logic          o_ls_err;

    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic [3:0]    o_mem_bmask;
    logic          i_mem_ack;
    logic [31:0]   i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err,
        input  i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_size,
        output o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_ls_err,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        input  i_mem_ack, i_mem_rdata
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err,
        output i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_size,
        input  o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_ls_err,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        output i_mem_ack, i_mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter_byte_lane_gen.sv
// Combinational byte-lane decode: size + low address bits -> byte mask,
// lane-shifted write data and misalignment flag.
module byte_lane_gen
    import mem_arb_pkg::*;
(
    input  logic [1:0]    i_size,
    input  logic [1:0]    i_addr_lo,
    input  logic [DW-1:0] i_wdata,
    output logic [BW-1:0] o_bmask_c,
    output logic [DW-1:0] o_wdata_c,
    output logic          o_misalign_c
);

    always_comb begin : lane_decode
        o_bmask_c    = '1;
        o_wdata_c    = i_wdata;
        o_misalign_c = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_bmask_c = BW'(4'b0001 << i_addr_lo);
                o_wdata_c = i_wdata << {i_addr_lo, 3'b000};
            end
            SZ_HALF: begin
                o_bmask_c    = BW'(4'b0011 << {i_addr_lo[1], 1'b0});
                o_wdata_c    = i_wdata << {i_addr_lo, 3'b000};
                o_misalign_c = i_addr_lo[0];
            end
            // Word and the reserved 2'b11 code both behave as a full word.
            default: begin
                o_bmask_c    = '1;
                o_misalign_c = |i_addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-port memory.
// Define ARB_RR_EN for round-robin arbitration; otherwise LS has fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e        state_q, state_d;
    mem_req_t      req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          if_rvalid_q, if_rvalid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic          if_err_q, if_err_d;
    logic          ls_rvalid_q, ls_rvalid_d;
    logic [DW-1:0] ls_rdata_q, ls_rdata_d;
    logic          ls_err_q, ls_err_d;

`ifdef ARB_RR_EN
    owner_e        last_q, last_d;
`endif

    logic          any_req, pick_ls, timeout;
    owner_e        win_owner;
    logic [1:0]    sel_size;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [BW-1:0] lane_bmask;
    logic [DW-1:0] lane_wdata;
    logic          lane_misalign;
    logic          if_gnt_c, ls_gnt_c;

    // Winner selection; IF is fed through the lane decoder as a word access.
    always_comb begin : arb_sel
        any_req = bus.i_if_req | bus.i_ls_req;
`ifdef ARB_RR_EN
        pick_ls = bus.i_ls_req & (~bus.i_if_req | (last_q == OWN_IF));
`else
        pick_ls = bus.i_ls_req;
`endif
        win_owner = pick_ls ? OWN_LS : OWN_IF;
        sel_size  = pick_ls ? bus.i_ls_size  : SZ_WORD;
        sel_addr  = pick_ls ? bus.i_ls_addr  : bus.i_if_addr;
        sel_wdata = pick_ls ? bus.i_ls_wdata : '0;
        timeout   = (cnt_q == CW'(TIMEOUT_CYC - 1));
    end

    byte_lane_gen u_lane (
        .i_size       (sel_size),
        .i_addr_lo    (sel_addr[1:0]),
        .i_wdata      (sel_wdata),
        .o_bmask_c    (lane_bmask),
        .o_wdata_c    (lane_wdata),
        .o_misalign_c (lane_misalign)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin : state_reg
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = lane_misalign ? RESP : BUSY;
            BUSY:    if (bus.i_mem_ack || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : out_comb
        if_gnt_c    = 1'b0;
        ls_gnt_c    = 1'b0;
        req_d       = req_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = 1'b0;
        ls_rvalid_d = 1'b0;
        ls_rdata_d  = ls_rdata_q;
        ls_err_d    = 1'b0;
`ifdef ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    if_gnt_c    = ~pick_ls;
                    ls_gnt_c    = pick_ls;
                    req_d.owner = win_owner;
                    req_d.we    = pick_ls & bus.i_ls_we;
                    req_d.bmask = lane_bmask;
                    req_d.wdata = lane_wdata;
                    addr_d      = {sel_addr[AW-1:2], 2'b00};
                    cnt_d       = '0;
                    err_d       = lane_misalign;
                    rdata_d     = '0;
`ifdef ARB_RR_EN
                    last_d      = win_owner;
`endif
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.i_mem_ack) begin
                    rdata_d = bus.i_mem_rdata;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            RESP: begin
                if (req_q.owner == OWN_LS) begin
                    ls_rvalid_d = 1'b1;
                    ls_rdata_d  = rdata_q;
                    ls_err_d    = err_q;
                end else begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = rdata_q;
                    if_err_d    = err_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin : data_reg
        if (i_reset) begin
            req_q       <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
            ls_err_q    <= 1'b0;
`ifdef ARB_RR_EN
            last_q      <= OWN_IF;
`endif
        end else begin
            req_q       <= req_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
            ls_err_q    <= ls_err_d;
`ifdef ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.o_if_gnt    = if_gnt_c;
    assign bus.o_ls_gnt    = ls_gnt_c;
    assign bus.o_if_rvalid = if_rvalid_q;
    assign bus.o_if_rdata  = if_rdata_q;
    assign bus.o_if_err    = if_err_q;
    assign bus.o_ls_rvalid = ls_rvalid_q;
    assign bus.o_ls_rdata  = ls_rdata_q;
    assign bus.o_ls_err    = ls_err_q;
    // Memory request is a pure decode of the state flop, so reset drops it at once.
    assign bus.o_mem_req   = (state_q == BUSY);
    assign bus.o_mem_we    = req_q.we;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = req_q.wdata;
    assign bus.o_mem_bmask = req_q.bmask;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT_CYC = 4).
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32)) bus ();

    mem_port_arbiter #(.AW(32), .TIMEOUT_CYC(TO)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.i_if_req    = 1'b0;
        bus.i_if_addr   = '0;
        bus.i_ls_req    = 1'b0;
        bus.i_ls_we     = 1'b0;
        bus.i_ls_addr   = '0;
        bus.i_ls_wdata  = '0;
        bus.i_ls_size   = SZ_WORD;
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = '0;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        #12;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        logic [9:0] ctl;
        idle_inputs();
        rst = 1'b1;
        #12;
        ctl = {bus.o_mem_req, bus.o_mem_we, bus.o_if_gnt, bus.o_ls_gnt, bus.o_if_rvalid,
               bus.o_ls_rvalid, bus.o_if_err, bus.o_ls_err, 2'b00};
        checks++;
        if (ctl !== 10'b0) begin errors++; $display("FAIL reset_ctl: got %b expected 0", ctl); end
        checks++;
        if ({bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_bmask} !== 68'h0) begin
            errors++; $display("FAIL reset_mem_fields: addr %h wdata %h bmask %b expected 0",
                               bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_bmask);
        end
        checks++;
        if ({bus.o_if_rdata, bus.o_ls_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: if %h ls %h expected 0", bus.o_if_rdata, bus.o_ls_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        // Stray ack in IDLE must not produce any response.
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.i_mem_ack = 1'b0;
        tick();
        checks++;
        if ({bus.o_if_rvalid, bus.o_ls_rvalid, bus.o_mem_req} !== 3'b000) begin
            errors++; $display("FAIL idle_ack_ignored: rv_if %b rv_ls %b req %b expected 0",
                               bus.o_if_rvalid, bus.o_ls_rvalid, bus.o_mem_req);
        end
    endtask

    task automatic test_if_read;
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 32'h100;
        #1;
        checks++;
        if ({bus.o_if_gnt, bus.o_ls_gnt} !== 2'b10) begin
            errors++; $display("FAIL if_gnt: got %b expected 10", {bus.o_if_gnt, bus.o_ls_gnt});
        end
        tick();
        bus.i_if_req = 1'b0;
        checks++;
        if ({bus.o_mem_req, bus.o_mem_we, bus.o_mem_bmask} !== 6'b101111 || bus.o_mem_addr !== 32'h100) begin
            errors++; $display("FAIL if_mem_port: req %b we %b bmask %b addr %h expected 1 0 1111 100",
                               bus.o_mem_req, bus.o_mem_we, bus.o_mem_bmask, bus.o_mem_addr);
        end
        tick();
        tick();
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = '0;
        checks++;
        if (bus.o_if_rvalid !== 1'b0) begin errors++; $display("FAIL if_rvalid_early: got %b expected 0", bus.o_if_rvalid); end
        tick();
        checks++;
        if (bus.o_if_rvalid !== 1'b1 || bus.o_if_rdata !== 32'hDEAD_BEEF || bus.o_if_err !== 1'b0 || bus.o_ls_rvalid !== 1'b0) begin
            errors++; $display("FAIL if_resp: rvalid %b rdata %h err %b ls_rvalid %b expected 1 deadbeef 0 0",
                               bus.o_if_rvalid, bus.o_if_rdata, bus.o_if_err, bus.o_ls_rvalid);
        end
        tick();
        checks++;
        if (bus.o_if_rvalid !== 1'b0) begin errors++; $display("FAIL if_rvalid_pulse: got %b expected 0", bus.o_if_rvalid); end
    endtask

    task automatic test_store_lanes;
        logic [1:0]  sz  [5] = '{SZ_BYTE, SZ_HALF, SZ_BYTE, SZ_WORD, 2'b11};
        logic [31:0] ad  [5] = '{32'h203, 32'h102, 32'h001, 32'h300, 32'h304};
        logic [31:0] wd  [5] = '{32'hAB, 32'hBEEF, 32'h5A, 32'hCAFE_F00D, 32'h1122_3344};
        logic [3:0]  ebm [5] = '{4'b1000, 4'b1100, 4'b0010, 4'b1111, 4'b1111};
        logic [31:0] ewd [5] = '{32'hAB00_0000, 32'hBEEF_0000, 32'h0000_5A00, 32'hCAFE_F00D, 32'h1122_3344};
        logic [31:0] ead [5] = '{32'h200, 32'h100, 32'h000, 32'h300, 32'h304};
        for (int i = 0; i < 5; i++) begin
            bus.i_ls_req   = 1'b1;
            bus.i_ls_we    = 1'b1;
            bus.i_ls_size  = sz[i];
            bus.i_ls_addr  = ad[i];
            bus.i_ls_wdata = wd[i];
            #1;
            checks++;
            if ({bus.o_if_gnt, bus.o_ls_gnt} !== 2'b01) begin
                errors++; $display("FAIL st_gnt[%0d]: got %b expected 01", i, {bus.o_if_gnt, bus.o_ls_gnt});
            end
            tick();
            bus.i_ls_req = 1'b0;
            checks++;
            if (bus.o_mem_req !== 1'b1 || bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== ead[i] ||
                bus.o_mem_bmask !== ebm[i] || bus.o_mem_wdata !== ewd[i]) begin
                errors++; $display("FAIL st_lane[%0d]: req %b we %b addr %h bmask %b wdata %h expected 1 1 %h %b %h",
                                   i, bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_bmask,
                                   bus.o_mem_wdata, ead[i], ebm[i], ewd[i]);
            end
            bus.i_mem_ack = 1'b1;
            tick();
            bus.i_mem_ack = 1'b0;
            tick();
            checks++;
            if (bus.o_ls_rvalid !== 1'b1 || bus.o_ls_err !== 1'b0) begin
                errors++; $display("FAIL st_done[%0d]: rvalid %b err %b expected 1 0", i, bus.o_ls_rvalid, bus.o_ls_err);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_misaligned;
        logic        is_ls [3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0]  sz    [3] = '{SZ_WORD, SZ_HALF, SZ_WORD};
        logic [31:0] ad    [3] = '{32'h202, 32'h101, 32'h102};
        for (int i = 0; i < 3; i++) begin
            bus.i_ls_req  = is_ls[i];
            bus.i_ls_we   = 1'b0;
            bus.i_ls_size = sz[i];
            bus.i_ls_addr = ad[i];
            bus.i_if_req  = ~is_ls[i];
            bus.i_if_addr = ad[i];
            #1;
            checks++;
            if ({bus.o_ls_gnt, bus.o_if_gnt} !== {is_ls[i], ~is_ls[i]}) begin
                errors++; $display("FAIL mis_gnt[%0d]: got %b expected %b", i, {bus.o_ls_gnt, bus.o_if_gnt}, {is_ls[i], ~is_ls[i]});
            end
            tick();
            idle_inputs();
            checks++;
            if (bus.o_mem_req !== 1'b0) begin errors++; $display("FAIL mis_no_mem[%0d]: got %b expected 0", i, bus.o_mem_req); end
            tick();
            checks++;
            if ({bus.o_ls_rvalid, bus.o_ls_err, bus.o_if_rvalid, bus.o_if_err} !== {is_ls[i], is_ls[i], ~is_ls[i], ~is_ls[i]}) begin
                errors++; $display("FAIL mis_resp[%0d]: ls rv/err %b%b if rv/err %b%b expected ls_owner %b",
                                   i, bus.o_ls_rvalid, bus.o_ls_err, bus.o_if_rvalid, bus.o_if_err, is_ls[i]);
            end
            tick();
        end
    endtask

    task automatic test_timeout;
        int n = 0;
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 32'h400;
        #1;
        tick();
        bus.i_if_req = 1'b0;
        while (bus.o_mem_req === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n != TO) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected %0d", n, TO); end
        tick();
        checks++;
        if (bus.o_if_rvalid !== 1'b1 || bus.o_if_err !== 1'b1 || bus.o_if_rdata !== 32'h0 || bus.o_mem_req !== 1'b0) begin
            errors++; $display("FAIL timeout_resp: rvalid %b err %b rdata %h req %b expected 1 1 0 0",
                               bus.o_if_rvalid, bus.o_if_err, bus.o_if_rdata, bus.o_mem_req);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic exp_ls;
        int   waited;
        pulse_reset();
        bus.i_if_req   = 1'b1;
        bus.i_if_addr  = 32'h600;
        bus.i_ls_req   = 1'b1;
        bus.i_ls_we    = 1'b0;
        bus.i_ls_addr  = 32'h700;
        bus.i_ls_size  = SZ_WORD;
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
            exp_ls = (i % 2 == 0);
`else
            exp_ls = 1'b1;
`endif
            waited = 0;
            while (!(bus.o_if_gnt || bus.o_ls_gnt) && waited < 10) begin
                tick();
                waited++;
            end
            checks++;
            if (waited != 0) begin errors++; $display("FAIL b2b_latency[%0d]: waited %0d expected 0", i, waited); end
            checks++;
            if ({bus.o_ls_gnt, bus.o_if_gnt} !== {exp_ls, ~exp_ls}) begin
                errors++; $display("FAIL arb_order[%0d]: ls/if gnt %b expected %b", i, {bus.o_ls_gnt, bus.o_if_gnt}, {exp_ls, ~exp_ls});
            end
            tick();
            bus.i_mem_ack = 1'b1;
            tick();
            bus.i_mem_ack = 1'b0;
            tick();
            checks++;
            if ({bus.o_ls_rvalid, bus.o_if_rvalid} !== {exp_ls, ~exp_ls}) begin
                errors++; $display("FAIL b2b_rvalid[%0d]: ls/if %b expected %b", i, {bus.o_ls_rvalid, bus.o_if_rvalid}, {exp_ls, ~exp_ls});
            end
            if (i == 3) idle_inputs();
        end
        tick();
    endtask

    task automatic test_reset_mid_busy;
        bus.i_ls_req  = 1'b1;
        bus.i_ls_we   = 1'b0;
        bus.i_ls_addr = 32'h500;
        bus.i_ls_size = SZ_WORD;
        #1;
        tick();
        bus.i_ls_req = 1'b0;
        checks++;
        if (bus.o_mem_req !== 1'b1) begin errors++; $display("FAIL rst_busy_req: got %b expected 1", bus.o_mem_req); end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.o_mem_req !== 1'b0) begin errors++; $display("FAIL rst_async_drop: got %b expected 0", bus.o_mem_req); end
        tick();
        rst = 1'b0;
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = 32'h1234_5678;
        tick();
        bus.i_mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.o_ls_rvalid, bus.o_if_rvalid, bus.o_mem_req} !== 3'b000) begin
                errors++; $display("FAIL rst_no_resp[%0d]: ls_rv %b if_rv %b req %b expected 0",
                                   i, bus.o_ls_rvalid, bus.o_if_rvalid, bus.o_mem_req);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_store_lanes();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
